// File: rtl/complex_pkg.sv
// Shared types and defaults for the complex row packet feeder.
package complex_pkg;

  localparam int ELEMENT_WIDTH = 64;
  localparam int NO_OF_UNITS   = 8;
  localparam int HOLD_CYCLES   = 2;
  localparam int HOLD_W        = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    FULL = 2'd2,
    DONE = 2'd3
  } feeder_state_e;

  // One complex element: real part in the upper half, imaginary in the lower.
  typedef struct packed {
    logic [31:0] re;
    logic [31:0] im;
  } complex_t;

  // Ceiling division carried in 33 bits so a total near 2^32 cannot wrap.
  function automatic logic [31:0] ceil_div(input logic [31:0] num, input logic [31:0] den);
    logic [32:0] sum;
    logic [32:0] quo;
    sum = {1'b0, num} + {1'b0, den} - 33'd1;
    quo = sum / {1'b0, den};
    return quo[31:0];
  endfunction

endpackage

// File: rtl/complex_packet_assembler.sv
// Slot-indexed assembly of the two row packets. Slot 0 lands in the most
// significant element position; clear_i zeroes both buffers so a short final
// packet carries zeros in its unwritten slots.
module complex_packet_assembler #(
  parameter int ELEMENT_WIDTH = complex_pkg::ELEMENT_WIDTH,
  parameter int NO_OF_UNITS   = complex_pkg::NO_OF_UNITS,
  parameter int SLOT_W        = (NO_OF_UNITS > 1) ? $clog2(NO_OF_UNITS) : 1
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 clear_i,
  input  logic                                 wr_en_i,
  input  logic [SLOT_W-1:0]                    slot_i,
  input  logic [ELEMENT_WIDTH-1:0]             a_i,
  input  logic [ELEMENT_WIDTH-1:0]             b_i,
  output logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0] buf_a_o,
  output logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0] buf_b_o
);

  logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0] buf_a_q;
  logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0] buf_b_q;

  // Clear takes priority over a write; otherwise write the addressed slot.
  always_ff @(posedge clk) begin
    if (reset || clear_i) begin
      buf_a_q <= '0;
      buf_b_q <= '0;
    end else if (wr_en_i) begin
      buf_a_q[ELEMENT_WIDTH*(NO_OF_UNITS-int'(slot_i))-1 -: ELEMENT_WIDTH] <= a_i;
      buf_b_q[ELEMENT_WIDTH*(NO_OF_UNITS-int'(slot_i))-1 -: ELEMENT_WIDTH] <= b_i;
    end
  end

  assign buf_a_o = buf_a_q;
  assign buf_b_o = buf_b_q;

endmodule

// File: rtl/complex_row_packet_feeder.sv
// Row packet feeder: gathers element pairs into two NO_OF_UNITS-wide packets,
// publishes them with a read_now strobe, and holds each published packet
// stable for HOLD_CYCLES while the next one fills behind it.
//
//   state | meaning
//   IDLE  | waiting for start; no input accepted
//   FILL  | accepting pairs into the assembly buffers
//   FULL  | packet complete; waits for hold_cnt==0, then publishes
//   DONE  | last packet issued; done pulses next cycle, back to IDLE
module complex_row_packet_feeder
  import complex_pkg::feeder_state_e;
  import complex_pkg::IDLE;
  import complex_pkg::FILL;
  import complex_pkg::FULL;
  import complex_pkg::DONE;
  import complex_pkg::HOLD_W;
  import complex_pkg::ceil_div;
#(
  parameter int ELEMENT_WIDTH = complex_pkg::ELEMENT_WIDTH,
  parameter int NO_OF_UNITS   = complex_pkg::NO_OF_UNITS,
  parameter int HOLD_CYCLES   = complex_pkg::HOLD_CYCLES
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic [31:0]                          total,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [ELEMENT_WIDTH-1:0]             in_a,
  input  logic [ELEMENT_WIDTH-1:0]             in_b,
  output logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0] first_row_output,
  output logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0] second_row_output,
  output logic                                 read_now,
  output logic                                 busy,
  output logic                                 done,
  output logic [31:0]                          packets_sent
);

  localparam int SLOT_W = (NO_OF_UNITS > 1) ? $clog2(NO_OF_UNITS) : 1;
  localparam int PKT_W  = ELEMENT_WIDTH * NO_OF_UNITS;
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NO_OF_UNITS - 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES);

  feeder_state_e     state_q, state_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [31:0]       elem_left_q, elem_left_d;
  logic [31:0]       pkt_total_q, pkt_total_d;
  logic [31:0]       packets_sent_q, packets_sent_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [PKT_W-1:0]  first_q, first_d;
  logic [PKT_W-1:0]  second_q, second_d;
  logic              read_now_q, read_now_d;
  logic              done_q, done_d;

  logic              wr_en;
  logic              clear;
  logic [PKT_W-1:0]  buf_a;
  logic [PKT_W-1:0]  buf_b;

  complex_packet_assembler #(
    .ELEMENT_WIDTH (ELEMENT_WIDTH),
    .NO_OF_UNITS   (NO_OF_UNITS),
    .SLOT_W        (SLOT_W)
  ) u_assembler (
    .clk     (clk),
    .reset   (reset),
    .clear_i (clear),
    .wr_en_i (wr_en),
    .slot_i  (slot_q),
    .a_i     (in_a),
    .b_i     (in_b),
    .buf_a_o (buf_a),
    .buf_b_o (buf_b)
  );

  // State and datapath registers; reset wins over every other input.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      slot_q         <= '0;
      elem_left_q    <= '0;
      pkt_total_q    <= '0;
      packets_sent_q <= '0;
      hold_q         <= '0;
      first_q        <= '0;
      second_q       <= '0;
      read_now_q     <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      slot_q         <= slot_d;
      elem_left_q    <= elem_left_d;
      pkt_total_q    <= pkt_total_d;
      packets_sent_q <= packets_sent_d;
      hold_q         <= hold_d;
      first_q        <= first_d;
      second_q       <= second_d;
      read_now_q     <= read_now_d;
      done_q         <= done_d;
    end
  end

  // Next-state logic: job setup, slot filling, hold-gated publish, done pulse.
  always_comb begin
    state_d        = state_q;
    slot_d         = slot_q;
    elem_left_d    = elem_left_q;
    pkt_total_d    = pkt_total_q;
    packets_sent_d = packets_sent_q;
    hold_d         = hold_q;
    first_d        = first_q;
    second_d       = second_q;
    read_now_d     = 1'b0;
    done_d         = 1'b0;
    wr_en          = 1'b0;
    clear          = 1'b0;

    // The hold timer only ever reloads from zero, so it can count freely here.
    if (hold_q != '0) begin
      hold_d = hold_q - 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          elem_left_d    = total;
          pkt_total_d    = ceil_div(total, 32'(NO_OF_UNITS));
          packets_sent_d = '0;
          slot_d         = '0;
          state_d        = (total == 32'd0) ? DONE : FILL;
        end
      end
      FILL: begin
        if (in_valid) begin
          wr_en       = 1'b1;
          elem_left_d = elem_left_q - 32'd1;
          slot_d      = slot_q + 1'b1;
          if (slot_q == LAST_SLOT || elem_left_q == 32'd1) begin
            state_d = FULL;
          end
        end
      end
      FULL: begin
        if (hold_q == '0) begin
          first_d        = buf_a;
          second_d       = buf_b;
          read_now_d     = 1'b1;
          hold_d         = HOLD_LOAD;
          packets_sent_d = packets_sent_q + 32'd1;
          slot_d         = '0;
          clear          = 1'b1;
          state_d        = (packets_sent_q + 32'd1 == pkt_total_q) ? DONE : FILL;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign in_ready          = (state_q == FILL);
  assign busy              = (state_q != IDLE);
  assign first_row_output  = first_q;
  assign second_row_output = second_q;
  assign read_now          = read_now_q;
  assign done              = done_q;
  assign packets_sent      = packets_sent_q;

endmodule

// File: tb/tb_complex_row_packet_feeder.sv
// Directed bench for complex_row_packet_feeder: a default instance (8 units,
// hold 2) and a small instance (2 units, hold 4) for the hold-stall scenario.
module tb_complex_row_packet_feeder;

  localparam int EW  = 64;
  localparam int NU  = 8;
  localparam int PW  = EW * NU;
  localparam int NU4 = 2;
  localparam int PW4 = EW * NU4;

  logic clk = 1'b0;
  logic reset;

  logic          start, in_valid, in_ready, read_now, busy, done;
  logic [31:0]   total, packets_sent;
  logic [EW-1:0] in_a, in_b;
  logic [PW-1:0] first_row_output, second_row_output;

  logic           start_h, in_valid_h, in_ready_h, read_now_h, busy_h, done_h;
  logic [31:0]    total_h, packets_sent_h;
  logic [EW-1:0]  in_a_h, in_b_h;
  logic [PW4-1:0] first_h, second_h;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  complex_row_packet_feeder dut (
    .clk(clk), .reset(reset), .start(start), .total(total),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .first_row_output(first_row_output), .second_row_output(second_row_output),
    .read_now(read_now), .busy(busy), .done(done), .packets_sent(packets_sent)
  );

  complex_row_packet_feeder #(.ELEMENT_WIDTH(64), .NO_OF_UNITS(2), .HOLD_CYCLES(4)) dut_h (
    .clk(clk), .reset(reset), .start(start_h), .total(total_h),
    .in_valid(in_valid_h), .in_ready(in_ready_h), .in_a(in_a_h), .in_b(in_b_h),
    .first_row_output(first_h), .second_row_output(second_h),
    .read_now(read_now_h), .busy(busy_h), .done(done_h), .packets_sent(packets_sent_h)
  );

  // Expected 8-slot packet: slot k holds base+k for k<cnt, zero beyond.
  function automatic logic [PW-1:0] pack8(input logic [63:0] base, input int cnt);
    logic [PW-1:0] r;
    r = '0;
    for (int k = 0; k < NU; k++)
      if (k < cnt) r[EW*(NU-k)-1 -: EW] = base + 64'(k);
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (read_now !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL reset_strobes got %b%b want 00", read_now, done); end
    n_cmp++; if (packets_sent !== 32'd0) begin n_err++; $display("FAIL reset_packets got %0d want 0", packets_sent); end
    n_cmp++; if (first_row_output !== '0 || second_row_output !== '0) begin n_err++; $display("FAIL reset_outputs not zero"); end
    reset = 1'b0;
    step();
    n_cmp++; if (in_ready !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL idle_after_reset got ready %b busy %b want 0 0", in_ready, busy); end
  endtask

  task automatic test_single();
    total = 32'd8; start = 1'b1;
    step();
    start = 1'b0;
    n_cmp++; if (in_ready !== 1'b1 || busy !== 1'b1) begin n_err++; $display("FAIL single_fill got ready %b busy %b want 1 1", in_ready, busy); end
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1; in_a = 64'(k + 1); in_b = 64'(16 + k);
      step();
    end
    in_valid = 1'b0;
    n_cmp++; if (read_now !== 1'b0 || in_ready !== 1'b0) begin n_err++; $display("FAIL single_full got read_now %b ready %b want 0 0", read_now, in_ready); end
    step();
    n_cmp++; if (read_now !== 1'b1) begin n_err++; $display("FAIL single_latency got read_now %b want 1", read_now); end
    n_cmp++; if (first_row_output[511:448] !== 64'd1) begin n_err++; $display("FAIL single_slot0 got %h want 1", first_row_output[511:448]); end
    n_cmp++; if (first_row_output !== pack8(64'd1, 8)) begin n_err++; $display("FAIL single_first got %h want %h", first_row_output, pack8(64'd1, 8)); end
    n_cmp++; if (second_row_output !== pack8(64'h10, 8)) begin n_err++; $display("FAIL single_second got %h want %h", second_row_output, pack8(64'h10, 8)); end
    n_cmp++; if (packets_sent !== 32'd1) begin n_err++; $display("FAIL single_packets got %0d want 1", packets_sent); end
    step();
    n_cmp++; if (done !== 1'b1 || read_now !== 1'b0) begin n_err++; $display("FAIL single_done got done %b read_now %b want 1 0", done, read_now); end
    step();
    n_cmp++; if (done !== 1'b0 || busy !== 1'b0 || packets_sent !== 32'd1) begin n_err++; $display("FAIL single_after got done %b busy %b pkts %0d want 0 0 1", done, busy, packets_sent); end
  endtask

  task automatic test_short_packet();
    int idx, pulses, last_t, min_gap, dones;
    logic acc;
    logic [PW-1:0] p1a, p3a, p3b;
    idx = 0; pulses = 0; last_t = -100; min_gap = 1000; dones = 0;
    p1a = '0; p3a = '1; p3b = '1;
    total = 32'd20; start = 1'b1;
    step();
    start = 1'b0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      in_valid = (idx < 20);
      in_a = 64'(idx + 1);
      in_b = 64'(256 + idx);
      acc = in_ready && in_valid;
      step();
      if (acc) idx++;
      if (read_now) begin
        pulses++;
        if (cyc - last_t < min_gap) min_gap = cyc - last_t;
        last_t = cyc;
        if (pulses == 1) p1a = first_row_output;
        if (pulses == 3) begin p3a = first_row_output; p3b = second_row_output; end
      end
      if (done) dones++;
    end
    in_valid = 1'b0;
    n_cmp++; if (pulses !== 3) begin n_err++; $display("FAIL short_pulses got %0d want 3", pulses); end
    n_cmp++; if (min_gap < 3) begin n_err++; $display("FAIL short_spacing got %0d want >=3", min_gap); end
    n_cmp++; if (idx !== 20) begin n_err++; $display("FAIL short_accepts got %0d want 20", idx); end
    n_cmp++; if (p1a !== pack8(64'd1, 8)) begin n_err++; $display("FAIL short_pkt1 got %h want %h", p1a, pack8(64'd1, 8)); end
    n_cmp++; if (p3a[255:0] !== 256'd0) begin n_err++; $display("FAIL short_zero_slots got %h want 0", p3a[255:0]); end
    n_cmp++; if (p3a !== pack8(64'd17, 4)) begin n_err++; $display("FAIL short_pkt3a got %h want %h", p3a, pack8(64'd17, 4)); end
    n_cmp++; if (p3b !== pack8(64'd272, 4)) begin n_err++; $display("FAIL short_pkt3b got %h want %h", p3b, pack8(64'd272, 4)); end
    n_cmp++; if (packets_sent !== 32'd3) begin n_err++; $display("FAIL short_packets got %0d want 3", packets_sent); end
    n_cmp++; if (dones !== 1 || busy !== 1'b0) begin n_err++; $display("FAIL short_done got %0d pulses busy %b want 1 0", dones, busy); end
  endtask

  task automatic test_hold_stall();
    total_h = 32'd4; start_h = 1'b1;
    step();
    start_h = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_valid_h = 1'b1; in_a_h = 64'(k + 1); in_b_h = 64'(32 + k);
      step();
    end
    in_a_h = 64'd99; in_b_h = 64'd99;
    n_cmp++; if (in_ready_h !== 1'b0) begin n_err++; $display("FAIL hold_full_ready got %b want 0", in_ready_h); end
    step();
    n_cmp++; if (read_now_h !== 1'b1 || first_h !== {64'd1, 64'd2} || second_h !== {64'd32, 64'd33}) begin
      n_err++; $display("FAIL hold_pkt1 got rn %b %h %h want 1 pkt 1,2 / 32,33", read_now_h, first_h, second_h); end
    in_a_h = 64'd3; in_b_h = 64'd34;
    step();
    n_cmp++; if (read_now_h !== 1'b0 || first_h !== {64'd1, 64'd2}) begin n_err++; $display("FAIL hold_early got rn %b %h", read_now_h, first_h); end
    in_a_h = 64'd4; in_b_h = 64'd35;
    step();
    in_a_h = 64'd77; in_b_h = 64'd77;
    for (int j = 0; j < 3; j++) begin
      n_cmp++; if (in_ready_h !== 1'b0 || read_now_h !== 1'b0) begin n_err++; $display("FAIL hold_stall%0d got ready %b rn %b want 0 0", j, in_ready_h, read_now_h); end
      n_cmp++; if (first_h !== {64'd1, 64'd2} || second_h !== {64'd32, 64'd33}) begin n_err++; $display("FAIL hold_stable%0d got %h %h", j, first_h, second_h); end
      step();
    end
    n_cmp++; if (read_now_h !== 1'b1 || first_h !== {64'd3, 64'd4} || second_h !== {64'd34, 64'd35}) begin
      n_err++; $display("FAIL hold_pkt2 got rn %b %h %h want 1 pkt 3,4 / 34,35", read_now_h, first_h, second_h); end
    n_cmp++; if (packets_sent_h !== 32'd2) begin n_err++; $display("FAIL hold_packets got %0d want 2", packets_sent_h); end
    in_valid_h = 1'b0;
    step();
    n_cmp++; if (done_h !== 1'b1) begin n_err++; $display("FAIL hold_done got %b want 1", done_h); end
    step();
  endtask

  task automatic test_zero_total();
    total = 32'd0; start = 1'b1;
    step();
    start = 1'b0;
    n_cmp++; if (done !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL zero_c1 got done %b busy %b want 0 1", done, busy); end
    step();
    n_cmp++; if (done !== 1'b1 || read_now !== 1'b0 || packets_sent !== 32'd0) begin
      n_err++; $display("FAIL zero_c2 got done %b rn %b pkts %0d want 1 0 0", done, read_now, packets_sent); end
    step();
    n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL zero_c3 got done %b busy %b want 0 0", done, busy); end
  endtask

  task automatic test_ignore_inputs();
    total = 32'd8; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1; in_a = 64'(64 + k); in_b = 64'(80 + k);
      if (k == 3) begin start = 1'b1; total = 32'd3; end
      step();
      start = 1'b0;
    end
    in_a = 64'hDEAD; in_b = 64'hDEAD;
    step();
    n_cmp++; if (read_now !== 1'b1 || first_row_output !== pack8(64'd64, 8) || second_row_output !== pack8(64'd80, 8)) begin
      n_err++; $display("FAIL ignore_pkt got rn %b %h %h", read_now, first_row_output, second_row_output); end
    step();
    n_cmp++; if (done !== 1'b1 || packets_sent !== 32'd1) begin n_err++; $display("FAIL ignore_done got done %b pkts %0d want 1 1", done, packets_sent); end
    step();
    step();
    n_cmp++; if (read_now !== 1'b0 || busy !== 1'b0 || packets_sent !== 32'd1 || first_row_output !== pack8(64'd64, 8)) begin
      n_err++; $display("FAIL ignore_idle got rn %b busy %b pkts %0d", read_now, busy, packets_sent); end
    in_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic stray;
    stray = 1'b0;
    total = 32'd8; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; in_a = 64'(96 + k); in_b = 64'(96 + k);
      step();
    end
    reset = 1'b1; start = 1'b1; in_valid = 1'b1;
    step();
    n_cmp++; if (first_row_output !== '0 || second_row_output !== '0) begin n_err++; $display("FAIL rstmid_outputs not zero"); end
    n_cmp++; if (packets_sent !== 32'd0 || busy !== 1'b0 || in_ready !== 1'b0 || read_now !== 1'b0 || done !== 1'b0) begin
      n_err++; $display("FAIL rstmid_ctrl got pkts %0d busy %b ready %b rn %b done %b want all 0", packets_sent, busy, in_ready, read_now, done); end
    reset = 1'b0; start = 1'b0; in_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (read_now || done || busy) stray = 1'b1;
    end
    n_cmp++; if (stray !== 1'b0) begin n_err++; $display("FAIL rstmid_stray got %b want 0", stray); end
    total = 32'd8; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1; in_a = 64'(112 + k); in_b = 64'(128 + k);
      step();
    end
    in_valid = 1'b0;
    step();
    n_cmp++; if (read_now !== 1'b1 || first_row_output !== pack8(64'd112, 8) || second_row_output !== pack8(64'd128, 8)) begin
      n_err++; $display("FAIL rstmid_newjob got rn %b %h %h", read_now, first_row_output, second_row_output); end
    step();
    step();
  endtask

  task automatic test_max_total();
    total = 32'hFFFF_FFFF; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1; in_a = 64'(k); in_b = 64'(k);
      step();
    end
    in_valid = 1'b0;
    step();
    n_cmp++; if (read_now !== 1'b1 || packets_sent !== 32'd1) begin n_err++; $display("FAIL max_first got rn %b pkts %0d want 1 1", read_now, packets_sent); end
    step();
    n_cmp++; if (busy !== 1'b1 || done !== 1'b0 || in_ready !== 1'b1) begin
      n_err++; $display("FAIL max_continue got busy %b done %b ready %b want 1 0 1", busy, done, in_ready); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; total = '0; in_valid = 1'b0; in_a = '0; in_b = '0;
    start_h = 1'b0; total_h = '0; in_valid_h = 1'b0; in_a_h = '0; in_b_h = '0;
    test_reset();
    test_single();
    test_short_packet();
    test_hold_stall();
    test_zero_total();
    test_ignore_inputs();
    test_reset_mid();
    test_max_total();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
